// File: rtl/arb_mux_if.sv
// Request/response bundle between the N-channel producers, the arbiter and the
// single downstream consumer. slave = arbiter side, master = surrounding logic.
interface arb_mux_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       i_valid;
  logic [CHANNELS*WIDTH-1:0] i_data;
  logic [CHANNELS-1:0]       o_ready;
  logic                      o_valid;
  logic [WIDTH-1:0]          o_data;
  logic [CW-1:0]             o_chan;
  logic                      i_ready;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_chan
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_chan
  );
endinterface

// File: rtl/arb_mux.sv
// N-to-1 arbitrating mux with a single registered output stage.
// Round-robin or fixed-priority grant; full throughput under continuous accept.
module arb_mux #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int RR_MODE  = 1
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  arb_mux_if.slave bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CW-1:0]                  ptr;
  logic                           valid_q;
  logic [WIDTH-1:0]               data_q;
  logic [CW-1:0]                  chan_q;

  logic                           load_en;
  logic [CHANNELS-1:0]            grant;
  logic [CW-1:0]                  sel;
  logic                           found;
  logic                           xfer;
  logic [CHANNELS-1:0][WIDTH-1:0] masked;
  logic [WIDTH-1:0]               sel_data;

  assign load_en = !valid_q || bus.i_ready;

  // Search order starts at ptr in round-robin mode, at 0 otherwise.
  always_comb begin
    int idx;
    grant = '0;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (RR_MODE != 0) begin
        idx = int'(ptr) + i;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
      end else begin
        idx = i;
      end
      if (!found && bus.i_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        sel        = CW'(idx);
      end
    end
  end

  assign bus.o_ready = load_en ? grant : '0;
  assign xfer        = load_en && found;

  // One-hot AND-OR select keeps the data path off the ready path.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_mask
    assign masked[k] = bus.i_data[k*WIDTH +: WIDTH] & {WIDTH{grant[k]}};
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) sel_data = sel_data | masked[k];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      ptr     <= '0;
    end else if (load_en) begin
      valid_q <= xfer;
      if (xfer) begin
        data_q <= sel_data;
        chan_q <= sel;
        ptr    <= (sel == CW'(CHANNELS - 1)) ? '0 : sel + CW'(1);
      end
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_chan  = chan_q;
endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: round-robin, fixed-priority and a 3-channel
// byte-wide instance, each driven by hand vectors with hand-computed results.
module tb_arb_mux;
  logic gclk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  arb_mux_if #(.WIDTH(16), .CHANNELS(4)) a_if ();
  arb_mux_if #(.WIDTH(16), .CHANNELS(4)) f_if ();
  arb_mux_if #(.WIDTH(8),  .CHANNELS(3)) p_if ();

  arb_mux #(.WIDTH(16), .CHANNELS(4), .RR_MODE(1)) u_rr (.i_clk(gclk), .i_rst_n(rst_n), .bus(a_if.slave));
  arb_mux #(.WIDTH(16), .CHANNELS(4), .RR_MODE(0)) u_fp (.i_clk(gclk), .i_rst_n(rst_n), .bus(f_if.slave));
  arb_mux #(.WIDTH(8),  .CHANNELS(3), .RR_MODE(1)) u_p3 (.i_clk(gclk), .i_rst_n(rst_n), .bus(p_if.slave));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_if.i_valid = '0; a_if.i_ready = 1'b0; a_if.i_data = '0;
    f_if.i_valid = '0; f_if.i_ready = 1'b0; f_if.i_data = '0;
    p_if.i_valid = '0; p_if.i_ready = 1'b0; p_if.i_data = '0;
    step();
    step();

    // reset state
    chk("rst_valid", 64'(a_if.o_valid), 64'h0);
    chk("rst_data",  64'(a_if.o_data),  64'h0);
    chk("rst_chan",  64'(a_if.o_chan),  64'h0);
    chk("rst_p3_valid", 64'(p_if.o_valid), 64'h0);
    rst_n = 1'b1;

    // fixed priority: lowest of 1010 is channel 1, every cycle
    f_if.i_data  = {16'h0B03, 16'h0B02, 16'h0B01, 16'h0B00};
    f_if.i_valid = 4'b1010;
    f_if.i_ready = 1'b1;
    #1;
    chk("fp_ready0", 64'(f_if.o_ready), 64'h2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fp_chan",  64'(f_if.o_chan),  64'h1);
      chk("fp_data",  64'(f_if.o_data),  64'h0B01);
      chk("fp_valid", 64'(f_if.o_valid), 64'h1);
      chk("fp_ready", 64'(f_if.o_ready), 64'h2);
    end
    f_if.i_valid = '0;

    // round-robin sweep 0,1,2,3,0
    a_if.i_data  = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    a_if.i_valid = 4'b1111;
    a_if.i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_chan",  64'(a_if.o_chan),  64'(i % 4));
      chk("rr_data",  64'(a_if.o_data),  64'(16'h00A0 + (i % 4)));
      chk("rr_valid", 64'(a_if.o_valid), 64'h1);
    end
    // ptr now 1: load 1234 from channel 1
    a_if.i_valid = 4'b0010;
    a_if.i_data[16 +: 16] = 16'h1234;
    step();
    chk("bp_load", 64'(a_if.o_data), 64'h1234);

    // backpressure: three stalled cycles, nothing granted, word held
    a_if.i_ready = 1'b0;
    a_if.i_valid = 4'b0100;
    a_if.i_data[32 +: 16] = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 64'(a_if.o_ready), 64'h0);
      step();
      chk("bp_hold", 64'(a_if.o_data),  64'h1234);
      chk("bp_vld",  64'(a_if.o_valid), 64'h1);
    end
    a_if.i_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(a_if.o_ready), 64'h4);
    step();
    chk("bp_new_data", 64'(a_if.o_data), 64'h5678);
    chk("bp_new_chan", 64'(a_if.o_chan), 64'h2);

    // ptr=3, only channel 0 valid: wrap to 0, then ptr=1
    a_if.i_valid = 4'b0001;
    a_if.i_data[0 +: 16] = 16'hBEEF;
    #1;
    chk("wrap_ready", 64'(a_if.o_ready), 64'h1);
    step();
    chk("wrap_chan", 64'(a_if.o_chan), 64'h0);
    chk("wrap_data", 64'(a_if.o_data), 64'hBEEF);
    a_if.i_valid = 4'b0000;
    step();
    chk("idle_valid", 64'(a_if.o_valid), 64'h0);
    chk("idle_hold",  64'(a_if.o_data),  64'hBEEF);
    a_if.i_valid = 4'b1111;
    a_if.i_data  = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    step();
    chk("after_wrap_chan", 64'(a_if.o_chan), 64'h1);

    // mid-operation reset with o_valid=1 and ptr=2
    rst_n = 1'b0;
    step();
    chk("mrst_valid", 64'(a_if.o_valid), 64'h0);
    chk("mrst_data",  64'(a_if.o_data),  64'h0);
    chk("mrst_chan",  64'(a_if.o_chan),  64'h0);
    rst_n = 1'b1;
    step();
    chk("mrst_first_chan",  64'(a_if.o_chan),  64'h0);
    chk("mrst_first_data",  64'(a_if.o_data),  64'h00A0);
    chk("mrst_first_valid", 64'(a_if.o_valid), 64'h1);
    step();
    chk("mrst_second_chan", 64'(a_if.o_chan), 64'h1);
    a_if.i_valid = '0;

    // 3-channel byte-wide instance: 0,1,2,0
    p_if.i_data  = {8'h12, 8'h11, 8'h10};
    p_if.i_valid = 3'b111;
    p_if.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("p3_chan", 64'(p_if.o_chan), 64'(i % 3));
      chk("p3_data", 64'(p_if.o_data), 64'(8'h10 + (i % 3)));
    end
    p_if.i_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001: Parameter WIDTH, default 16, bits per data word (1..64).
REQ-002: Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003: Parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
REQ-004: Localparam CW = ceil(log2(CHANNELS)), the channel-index width.
REQ-005: i_clk  input  1  the single clock; all state updates on the rising edge.
REQ-006: i_rst_n  input  1  reset, synchronous and active-low, sampled on the i_clk rising edge.
REQ-007: i_valid  input  CHANNELS  per-channel request; bit k = channel k.
REQ-008: i_data  input  CHANNELS*WIDTH  packed words; channel k occupies bits k*WIDTH+WIDTH-1 .. k*WIDTH.
REQ-009: o_ready  output  CHANNELS  per-channel accept; a word on channel k transfers when i_valid[k] and o_ready[k] are both 1.
REQ-010: o_valid  output  1  the output register holds a word.
REQ-011: o_data  output  WIDTH  the registered selected word.
REQ-012: o_chan  output  CW  the source channel index of o_data.
REQ-013: i_ready  input  1  the downstream accepts o_data when o_valid and i_ready are both 1.

Function
REQ-014: load_en = !o_valid || i_ready, combinational.
REQ-015: grant is one-hot or zero; it is zero when i_valid is all zeros.
- RR_MODE=1: first asserted i_valid bit searching from ptr upward, wrapping at CHANNELS-1 to 0.
- RR_MODE=0: lowest asserted index.
REQ-016: o_ready[k] = load_en && grant[k], combinational; at most one o_ready bit is high per cycle, and no o_ready bit depends on any i_data bit.
REQ-017: On a transfer from channel k, o_data <= word k, o_chan <= k and o_valid <= 1 at the next edge (latency 1 cycle).
REQ-018: If load_en is 1 and no channel transfers, o_valid <= 0; o_data and o_chan hold.
REQ-019: If load_en is 0, o_valid, o_data and o_chan hold unchanged, and every o_ready bit is 0.
REQ-020: A downstream accept and a new load may occur in the same cycle, giving full throughput of 1 word/cycle with no bubble.
REQ-021: Round-robin pointer ptr (CW bits):
- After a transfer from channel k, ptr <= (k+1) mod CHANNELS, with wrap to 0 after CHANNELS-1.
- Otherwise ptr holds.
- ptr is unused when RR_MODE=0.
REQ-022: With all channels continuously valid, RR_MODE=1 serves channels in order 0,1,...,CHANNELS-1,0, and each channel is served exactly once per CHANNELS transfers.
REQ-023: Starvation bound for RR_MODE=1: a continuously valid channel transfers within CHANNELS load_en cycles.
REQ-024: A channel's i_valid may drop without a transfer; the arbiter re-evaluates every cycle and does not lock onto a channel.
REQ-025: o_data and o_chan change only on cycles with a transfer or reset; their values while o_valid=0 are don't-care, except after reset.

Reset
REQ-026: When i_rst_n=0 at an edge, the following values are set at that edge:
- o_valid <= 0
- o_data <= 0
- o_chan <= 0
- ptr <= 0
REQ-027: During a reset cycle, no transfer is recorded, even if i_valid and o_ready coincide.
REQ-028: Reset mid-operation discards the buffered word and re-arms arbitration from channel 0.
REQ-029: The first edge with i_rst_n=1 behaves as a normal cycle with load_en=1.

Verification
REQ-030: Fixed priority: RR_MODE=0, i_valid=4'b1010, i_ready=1 -> o_ready=4'b0010, o_chan=1 next cycle, repeated every cycle while inputs hold.
REQ-031: Round-robin sweep: RR_MODE=1, i_valid=4'b1111, i_ready=1, data words 16'h00A0..16'h00A3 -> o_chan sequence 0,1,2,3,0 and o_data sequence A0,A1,A2,A3,A0 with o_valid=1 every cycle.
REQ-032: Backpressure: o_valid=1 holding 16'h1234, i_ready=0 for 3 cycles with i_valid=4'b0100 -> o_ready=0 throughout and o_data stays 16'h1234; i_ready=1 -> 16'h1234 accepted and channel 2 word loaded the same edge.
REQ-033: Wrap and skip: ptr=3, i_valid=4'b0001 -> grant channel 0, then ptr=1; with i_valid=4'b0000 the next cycle and i_ready=1 -> o_valid=0.
REQ-034: Mid-operation reset: i_rst_n=0 for 1 cycle while o_valid=1 and ptr=2 -> o_valid=0, o_data=0, o_chan=0, ptr=0; with i_valid=4'b1111 afterwards, the first grant is channel 0.
REQ-035: Parameter sweep: WIDTH=8, CHANNELS=3, RR_MODE=1, all valid -> o_chan sequence 0,1,2,0 with CW=2.
